dpi_sensitive_sampler: RTL and testbench
========================================

Name: dpi_sensitive_sampler

Overview:
- Hardware-side front end for one DPI exporter sensitive group.
- Each cycle it evaluates the group's trigger condition: trigger changed since the previous sample, or trigger nonzero.
- On a hit it snapshots the group payload into a small FIFO, tagged with a sequence number.
- The downstream tick stage drains the FIFO through a valid/ready handshake and issues one dpi_exporter_tick_<group> call per entry. The tick side never misses a trigger because of back-pressure, and drops are counted.

Parameters:
- DATA_W, 64, width of the packed group payload (concatenated exported signals).
- TRIG_W, 1, width of the trigger signal.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the sequence and drop counters.

Ports:
- clock  in  1  sampling clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  sampling enable; when 0, no new captures.
- flush  in  1  single-cycle pulse; discards all FIFO contents.
- trig  in  TRIG_W  group trigger signal.
- data  in  DATA_W  group payload, sampled with trig.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_trig  out  TRIG_W  trigger value of the head entry.
- out_data  out  DATA_W  payload of the head entry.
- out_seq  out  CNT_W  sequence number of the head entry.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  CNT_W  saturating count of dropped samples.
- overflow  out  1  sticky: set by any drop.

Behaviour:
- Reset (async assert, sync-released by the integrator):
  - trig_last=0, seq=0, drop_cnt=0, overflow=0, FIFO empty.
  - out_valid=0, level=0, out_trig/out_data/out_seq=0.
- Fire condition, evaluated at each posedge: fire = enable && ((trig ^ trig_last)!=0 || trig!=0).
- trig_last <= trig every cycle regardless of enable, so re-enabling never produces a spurious change hit.
- On fire:
  - The entry {trig, data, seq} is written to the FIFO.
  - seq <= seq+1, wrapping modulo 2^CNT_W.
  - seq increments on every fire, including dropped ones, so gaps in out_seq expose drops.
- Pop: pop = out_valid && out_ready at the posedge. The head advances.
- Push/pop rules:
  - Full and fire without pop: the sample is dropped. drop_cnt increments, saturating at all-ones. overflow <= 1.
  - Full and fire with pop in the same cycle: the push is accepted, no drop, level unchanged.
  - Empty and fire: the entry appears at the head one cycle later. Latency: fire at edge N gives out_valid=1 after edge N. There is no same-cycle bypass.
  - Empty and out_ready: no effect.
- Handshake:
  - out_valid = (level!=0).
  - The head fields are stable while out_valid && !out_ready.
  - out_valid never drops without a pop, except on flush or reset.
- Flush: at the posedge, the FIFO empties and level=0.
  - Takes priority over push and pop in the same cycle. The fire is still counted in seq but not stored and not counted as a drop.
  - drop_cnt, overflow, seq and trig_last are unaffected.
- Pointers: rd/wr pointers carry an extra wrap bit; full = (msb differ && lower bits equal).
- Data path has no arithmetic other than the counters.
- Reset asserted mid-stream: all state clears immediately; in-flight entries are lost.

Test Plan:
- Single pulse: TRIG_W=1. trig goes 0 -> 1 for 1 cycle, then 0, data=0xAA then 0xBB.
  - Fire on the rise (trig=1) and on the fall (change). Two entries: {1,0xAA,0} then {0,0xBB,1}.
  - No further entries while trig stays 0.
- Level-high hold: trig=1 for 3 cycles, out_ready=1.
  - 3 entries with seq 0,1,2, each valid one cycle after capture; level never exceeds 1.
- Back-pressure overflow: DEPTH=4, out_ready=0, trig=1 for 6 cycles.
  - level=4; drop_cnt=2; overflow=1.
  - Draining yields seq 0,1,2,3, data stable while stalled.
- Full with simultaneous pop: FIFO full, out_ready=1, trig=1.
  - No drop, level stays 4, drop_cnt unchanged.
  - The head advances to the next seq.
- Enable/flush:
  - enable=0 while trig toggles 0/1 for 4 cycles gives no entries and seq=0. Raising enable with trig=0, unchanged, gives no fire.
  - flush with 3 entries queued and a same-cycle fire gives level=0, drop_cnt unchanged, next captured seq one higher.
- Async reset mid-operation: assert reset between edges with level=3 and drop_cnt=5.
  - out_valid, level, drop_cnt, overflow go to 0 immediately, without waiting for a clock edge.
  - The first capture after release carries seq=0.

Source files
------------

// File: rtl/dpi_sensitive_sampler.sv
// dpi_sensitive_sampler
// Hardware front end for one DPI exporter sensitive group. Each cycle the
// group's trigger is evaluated; a hit snapshots {trig, data, seq} into a small
// FIFO that the downstream tick stage drains one entry per exporter call.
//
// Handshake: out_valid is high whenever the FIFO holds at least one entry.
// A transfer (pop) happens at a rising edge where out_valid && out_ready.
// While out_valid && !out_ready the head fields hold steady, and out_valid
// only falls after a pop, a flush or a reset.
//
// DEPTH must be a power of two and at least 2. The pointers carry one extra
// wrap bit so full and empty can be told apart without a separate counter.

module dpi_sensitive_sampler #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TRIG_W = 1,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [TRIG_W-1:0]        trig,
    input  logic [DATA_W-1:0]        data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TRIG_W-1:0]        out_trig,
    output logic [DATA_W-1:0]        out_data,
    output logic [CNT_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Entry storage, split per field so each slice keeps its natural width.
    logic [TRIG_W-1:0] mem_trig [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [CNT_W-1:0]  mem_seq  [DEPTH];

    // Registered state
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [TRIG_W-1:0] trig_last_q;
    logic [CNT_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    // Per-cycle decisions
    logic              fire;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  rd_idx;

    assign wr_idx = wr_ptr_q[PTR_W-1:0];
    assign rd_idx = rd_ptr_q[PTR_W-1:0];

    // Trigger evaluation and push/pop/drop arbitration; flush outranks both.
    always_comb begin
        fire  = enable && (((trig ^ trig_last_q) != '0) || (trig != '0));
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop   = !empty && out_ready && !flush;
        // A full FIFO still accepts a push when the head leaves in the same
        // cycle: the freed slot is the one being written.
        push  = fire && !flush && (!full || pop);
        drop  = fire && !flush && full && !pop;
    end

    // Next-state for pointers and counters.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        if (flush) begin
            // Discard everything by collapsing the read pointer onto write.
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end

        // Sequence advances on every fire, stored or not, so the consumer
        // can spot holes left by drops and flushes.
        if (fire) begin
            seq_d = seq_q + CNT_ONE;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_ONE;
            end
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_last_q <= '0;
            seq_q       <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            // Tracked even while disabled so re-enabling sees no stale change.
            trig_last_q <= trig;
            seq_q       <= seq_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Entry storage write; contents are only observed through a valid head.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_trig[wr_idx] <= trig;
            mem_data[wr_idx] <= data;
            mem_seq[wr_idx]  <= seq_q;
        end
    end

    // Head presentation, forced to zero when the FIFO is empty.
    always_comb begin
        out_valid = !empty;
        out_trig  = '0;
        out_data  = '0;
        out_seq   = '0;
        if (!empty) begin
            out_trig = mem_trig[rd_idx];
            out_data = mem_data[rd_idx];
            out_seq  = mem_seq[rd_idx];
        end
    end

    assign level    = wr_ptr_q - rd_ptr_q;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dpi_sensitive_sampler.sv
// Self-checking bench for dpi_sensitive_sampler: directed scenarios followed
// by randomized traffic, checked against a queue-based reference model.

module tb_dpi_sensitive_sampler;

    localparam int DW    = 64;
    localparam int TW    = 1;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int EW    = TW + DW + CW;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          flush;
    logic [TW-1:0] trig;
    logic [DW-1:0] data;
    logic          out_ready;
    logic          out_valid;
    logic [TW-1:0] out_trig;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_seq;
    logic [LW-1:0] level;
    logic [CW-1:0] drop_cnt;
    logic          overflow;

    always #5 clock = ~clock;

    dpi_sensitive_sampler #(
        .DATA_W(DW), .TRIG_W(TW), .DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .trig(trig), .data(data), .out_valid(out_valid), .out_ready(out_ready),
        .out_trig(out_trig), .out_data(out_data), .out_seq(out_seq),
        .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    // ---------------- scoreboard / model ----------------
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    int            m_seq;
    logic [TW-1:0] m_last;
    int            m_drop;
    logic          m_ovf;

    // Model view of the DUT state during the current cycle.
    int            cur_level;
    int            cur_drop;
    logic          cur_ovf;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_seq  = 0;
        m_last = '0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs and predicts what the coming edge does.
    task automatic step(input logic en, input logic fl, input logic [TW-1:0] tr,
                        input logic [DW-1:0] d, input logic rdy);
        bit fire;
        bit pop;
        @(negedge clock);
        #1;
        enable    = en;
        flush     = fl;
        trig      = tr;
        data      = d;
        out_ready = rdy;

        cur_level = exp_q.size();
        cur_drop  = m_drop;
        cur_ovf   = m_ovf;

        // A group fires when its trigger is nonzero or differs from last cycle.
        fire = en && ((tr != m_last) || (tr != '0));
        pop  = (cur_level != 0) && rdy && !fl;
        if (fire) begin
            if (!fl) begin
                if (cur_level < DEPTH || pop) begin
                    exp_q.push_back({tr, d, CW'(m_seq)});
                end else begin
                    if (m_drop < (1 << CW) - 1) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            m_seq = (m_seq + 1) % (1 << CW);
        end
        m_last = tr;
        mon_en = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (mon_en) begin
                check("level", level, cur_level);
                check("out_valid", out_valid, cur_level != 0);
                check("drop_cnt", drop_cnt, cur_drop);
                check("overflow", overflow, cur_ovf);
                if (cur_level != 0) begin
                    check("head", {out_trig, out_data, out_seq}, exp_q[0]);
                    if (out_ready && !flush) void'(exp_q.pop_front());
                end
                if (flush) exp_q.delete();
            end
        end
    end

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        flush     = 1'b0;
        trig      = '0;
        data      = '0;
        out_ready = 1'b0;
        model_reset();

        repeat (2) @(negedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_out_trig", out_trig, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_seq", out_seq, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clock);
        reset = 1'b0;

        // Single pulse: fires on the rise and on the fall, then stays quiet.
        step(1, 0, 0, 64'h11, 0);
        step(1, 0, 1, 64'hAA, 0);
        step(1, 0, 0, 64'hBB, 0);
        repeat (3) step(1, 0, 0, 64'hCC, 0);
        repeat (3) step(1, 0, 0, 64'hDD, 1);

        // Level-high hold with a ready consumer.
        repeat (3) step(1, 0, 1, rand_data(), 1);
        repeat (3) step(1, 0, 0, rand_data(), 1);

        // Build level=3, drop_cnt=5, then reset between edges.
        repeat (9) step(1, 0, 1, rand_data(), 0);
        step(0, 0, 0, rand_data(), 1);
        @(negedge clock);
        #1;
        mon_en = 1'b0;
        check("pre_rst_level", level, 3);
        check("pre_rst_drop_cnt", drop_cnt, 5);
        reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_level", level, 0);
        check("async_drop_cnt", drop_cnt, 0);
        check("async_overflow", overflow, 0);
        model_reset();
        enable    = 1'b0;
        trig      = '0;
        out_ready = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b0;
        step(1, 0, 1, 64'h5EED, 1);
        repeat (3) step(1, 0, 0, rand_data(), 1);

        // Back-pressure overflow, stall hold, then drain.
        repeat (6) step(1, 0, 1, rand_data(), 0);
        repeat (2) step(0, 0, 0, rand_data(), 0);
        check("ovf_level", level, 4);
        check("ovf_overflow", overflow, 1);
        repeat (5) step(0, 0, 0, rand_data(), 1);

        // Full with simultaneous pop.
        repeat (4) step(1, 0, 1, rand_data(), 0);
        repeat (3) step(1, 0, 1, rand_data(), 1);
        repeat (6) step(0, 0, 0, rand_data(), 1);

        // Enable low while trig toggles; re-enable with trig steady at 0.
        for (int i = 0; i < 4; i++) step(0, 0, TW'(~i[0]), rand_data(), 0);
        repeat (2) step(1, 0, 0, rand_data(), 0);
        // Flush with three queued and a same-cycle fire.
        repeat (3) step(1, 0, 1, rand_data(), 0);
        step(1, 1, 1, rand_data(), 1);
        step(1, 0, 1, rand_data(), 1);
        repeat (3) step(1, 0, 0, rand_data(), 1);

        // Randomized traffic with bursty back-pressure.
        for (int i = 0; i < 1500; i++) begin
            logic rdy;
            if ((i / 50) % 3 == 1) rdy = ($urandom_range(0, 4) == 0);
            else rdy = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 31) == 0,
                 ($urandom_range(0, 2) == 0) ? TW'($urandom) : '0,
                 rand_data(),
                 rdy);
        end

        // Drain.
        repeat (DEPTH + 2) step(0, 0, 0, '0, 1);
        @(negedge clock);
        #4;
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
